// File: rtl/uart_word_bridge_pkg.sv
// Shared state encodings and sizing helper for the UART word bridge.
package uart_word_bridge_pkg;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  function automatic int word_bytes(input int nb_word, input int nb_data);
    return nb_word / nb_data;
  endfunction

endpackage

// File: rtl/uart_word_bridge_serializer.sv
// uart_word_serializer: latches a word and feeds it to the UART transmitter
// one byte at a time, LSB byte first, pacing on the transmitter's done pulse.
module uart_word_serializer
  import uart_word_bridge_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_word_valid,
  output logic               o_word_ready,
  output logic [NB_DATA-1:0] o_tx_wdata,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_tx_full
);

  localparam int BYTES = word_bytes(NB_WORD, NB_DATA);
  localparam int NB_IDX = $clog2(BYTES);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BYTES - 1);

  tx_state_t          state;
  tx_state_t          state_next;
  logic [NB_WORD-1:0] word_q;
  logic [NB_IDX-1:0]  tx_idx;
  logic               launch;

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      TX_IDLE: if (i_word_valid) state_next = TX_SEND;
      TX_SEND: begin
        if (!i_tx_full) begin
          launch     = 1'b1;
          state_next = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_tx_done) state_next = (tx_idx == LAST_IDX) ? TX_IDLE : TX_SEND;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // The start pulse is registered so the byte and its strobe leave together.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= TX_IDLE;
      word_q     <= '0;
      tx_idx     <= '0;
      o_tx_wdata <= '0;
      o_tx_start <= 1'b0;
    end else begin
      state      <= state_next;
      o_tx_start <= launch;
      if (state == TX_IDLE && i_word_valid) begin
        word_q <= i_word;
        tx_idx <= '0;
      end
      if (launch) o_tx_wdata <= word_q[tx_idx*NB_DATA +: NB_DATA];
      if (state == TX_WAIT && i_tx_done && tx_idx != LAST_IDX) tx_idx <= tx_idx + 1'b1;
    end
  end

  assign o_word_ready = !i_rst && (state == TX_IDLE);

endmodule

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: assembles RX FIFO bytes into little-endian words and sends words out
// through uart_word_serializer. Define UART_WORD_BRIDGE_TIMEOUT_EN to drop stale partial RX words.
module uart_word_bridge
  import uart_word_bridge_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_WORD        = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int NB_TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_rdata,
  input  logic               i_rx_empty,
  output logic               o_rx_rd,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid,
  input  logic               i_word_ready,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_word_valid,
  output logic               o_word_ready,
  output logic [NB_DATA-1:0] o_tx_wdata,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_tx_full,
  output logic               o_rx_timeout
);

  localparam int BYTES = word_bytes(NB_WORD, NB_DATA);
  localparam int NB_IDX = $clog2(BYTES);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BYTES - 1);
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  rx_state_t         rx_state;
  rx_state_t         rx_state_next;
  logic [NB_IDX-1:0] rx_idx;
  logic              pop;
  logic              timeout_hit;

  assign pop          = !i_rst && (rx_state == RX_COLLECT) && !i_rx_empty;
  assign o_rx_rd      = pop;
  assign o_word_valid = !i_rst && (rx_state == RX_HOLD);
  assign o_rx_timeout = timeout_hit;

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_COLLECT: if (pop && rx_idx == LAST_IDX) rx_state_next = RX_HOLD;
      RX_HOLD:    if (i_word_ready) rx_state_next = RX_COLLECT;
      default:    rx_state_next = RX_COLLECT;
    endcase
  end

  // Bytes land directly in their lane of o_word; the word is only presented once in RX_HOLD.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_state <= RX_COLLECT;
      rx_idx   <= '0;
      o_word   <= '0;
    end else begin
      rx_state <= rx_state_next;
      if (pop) begin
        o_word[rx_idx*NB_DATA +: NB_DATA] <= i_rx_rdata;
        rx_idx <= (rx_idx == LAST_IDX) ? '0 : rx_idx + 1'b1;
      end else if (timeout_hit) begin
        rx_idx <= '0;
      end
    end
  end

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] to_cnt;
  logic                  starving;

  assign starving    = (rx_state == RX_COLLECT) && (rx_idx != '0) && i_rx_empty;
  assign timeout_hit = !i_rst && starving && (to_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (i_rst || !starving || timeout_hit) to_cnt <= '0;
    else to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_LAST;
  assign timeout_hit        = 1'b0;
`endif

  uart_word_serializer #(
    .NB_DATA(NB_DATA),
    .NB_WORD(NB_WORD)
  ) u_serializer (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_word      (i_word),
    .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready),
    .o_tx_wdata  (o_tx_wdata),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .i_tx_full   (i_tx_full)
  );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: FIFO, consumer, word source and UART models
// with a byte/word-level scoreboard; honours UART_WORD_BRIDGE_TIMEOUT_EN.
module tb_uart_word_bridge;

  localparam int BYTES      = 4;
  localparam int DONE_DELAY = 10;
  localparam int TO_CYCLES  = 16;

  logic        clk;
  logic        i_rst;
  logic [7:0]  i_rx_rdata;
  logic        i_rx_empty;
  logic        o_rx_rd;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic [31:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [7:0]  o_tx_wdata;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        i_tx_full;
  logic        o_rx_timeout;

  uart_word_bridge #(
    .NB_DATA(8),
    .NB_WORD(32),
    .TIMEOUT_CYCLES(TO_CYCLES),
    .NB_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_rx_rdata  (i_rx_rdata),
    .i_rx_empty  (i_rx_empty),
    .o_rx_rd     (o_rx_rd),
    .o_word      (o_word),
    .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready),
    .i_word      (i_word),
    .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready),
    .o_tx_wdata  (o_tx_wdata),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .i_tx_full   (i_tx_full),
    .o_rx_timeout(o_rx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: external FIFO, partial word, expected words/bytes, word source.
  logic [7:0]  fifo[$];
  logic [7:0]  part[$];
  logic [31:0] exp_words[$];
  logic [31:0] tx_src[$];
  logic [7:0]  tx_exp[$];

  int cyc = 0;
  int done_at = -1;
  int last_pop_cyc = 0;
  int last_done_cyc = 0;
  int pops = 0;
  int starts = 0;
  int dones = 0;
  int words_rx = 0;
  int valid_cycles = 0;
  int timeouts = 0;
  int gap_pct = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_word = '0;
  logic [31:0] last_rx_word = '0;
  logic [31:0] tx_shift = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs();
    i_word_valid = (tx_src.size() != 0);
    i_word       = (tx_src.size() != 0) ? tx_src[0] : 32'h0;
    i_rx_empty   = (fifo.size() == 0) || ($urandom_range(99) < gap_pct);
    i_rx_rdata   = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic clearModel();
    part.delete();
    exp_words.delete();
    tx_src.delete();
    tx_exp.delete();
    done_at   = -1;
    hold_prev = 1'b0;
  endtask

  // One clock cycle: score this cycle's outputs, take the edge, then drive the next cycle.
  task automatic applyStimulus();
    logic        pop_now, valid_now, hs_now, acc_now, start_now, to_now;
    logic [31:0] word_now, w;
    logic [7:0]  byte_now, b;
    pop_now   = o_rx_rd;
    valid_now = o_word_valid;
    hs_now    = o_word_valid && i_word_ready;
    word_now  = o_word;
    acc_now   = o_word_ready && i_word_valid;
    start_now = o_tx_start;
    byte_now  = o_tx_wdata;
    to_now    = o_rx_timeout;

    if (valid_now) begin
      valid_cycles++;
      checkOutput("rx_hold_no_pop", 64'(pop_now), 64'd0);
      if (hold_prev) checkOutput("rx_hold_stable", 64'(word_now), 64'(hold_word));
    end
    hold_prev = valid_now && !hs_now;
    hold_word = word_now;

    if (hs_now) begin
      checkOutput("rx_word_expected", 64'(exp_words.size() != 0), 64'd1);
      if (exp_words.size() != 0) checkOutput("rx_word", 64'(word_now), 64'(exp_words.pop_front()));
      words_rx++;
      last_rx_word = word_now;
    end

    if (pop_now) begin
      checkOutput("rx_pop_nonempty", 64'(fifo.size() != 0), 64'd1);
      if (fifo.size() != 0) begin
        b = fifo.pop_front();
        pops++;
        last_pop_cyc = cyc;
        part.push_back(b);
        if (part.size() == BYTES) begin
          w = '0;
          for (int i = 0; i < BYTES; i++) w = w | (32'(part[i]) << (8 * i));
          exp_words.push_back(w);
          part.delete();
        end
      end
    end

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    if (to_now) begin
      timeouts++;
      checkOutput("rx_timeout_delay", 64'(cyc - last_pop_cyc), 64'(TO_CYCLES));
      part.delete();
    end
`else
    if (to_now) timeouts++;
    checkOutput("rx_timeout_disabled", 64'(to_now), 64'd0);
`endif

    if (acc_now) begin
      for (int i = 0; i < BYTES; i++) tx_exp.push_back(i_word[8*i +: 8]);
      void'(tx_src.pop_front());
    end

    if (start_now) begin
      starts++;
      tx_shift = {byte_now, tx_shift[31:8]};
      checkOutput("tx_byte_expected", 64'(tx_exp.size() != 0), 64'd1);
      if (tx_exp.size() != 0) checkOutput("tx_byte", 64'(byte_now), 64'(tx_exp.pop_front()));
      done_at = cyc + DONE_DELAY;
    end

    @(posedge clk);
    #1;
    cyc++;
    i_tx_done = (cyc == done_at);
    if (i_tx_done) begin
      dones++;
      last_done_cyc = cyc;
    end
    driveInputs();
    #1;
  endtask

  initial begin
    int p0, s0, d0, w0, t0, n;
    logic [7:0] rb;

    i_rst        = 1'b1;
    i_rx_rdata   = 8'h00;
    i_rx_empty   = 1'b1;
    i_word_ready = 1'b1;
    i_word       = 32'h0;
    i_word_valid = 1'b0;
    i_tx_done    = 1'b0;
    i_tx_full    = 1'b0;
    #2;

    // Reset values
    checkOutput("rst_word_ready", 64'(o_word_ready), 64'd0);
    checkOutput("rst_rx_rd", 64'(o_rx_rd), 64'd0);
    repeat (3) applyStimulus();
    checkOutput("rst_word", 64'(o_word), 64'd0);
    checkOutput("rst_word_valid", 64'(o_word_valid), 64'd0);
    checkOutput("rst_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("rst_tx_wdata", 64'(o_tx_wdata), 64'd0);
    checkOutput("rst_rx_timeout", 64'(o_rx_timeout), 64'd0);
    i_rst = 1'b0;
    #1;
    checkOutput("post_rst_word_ready", 64'(o_word_ready), 64'd1);
    $display("[TB] reset checks done");

    // RX assembly of a known word
    p0 = pops;
    valid_cycles = 0;
    fifo.push_back(8'h78); fifo.push_back(8'h56); fifo.push_back(8'h34); fifo.push_back(8'h12);
    driveInputs();
    #1;
    repeat (12) applyStimulus();
    checkOutput("rx_first_word", 64'(last_rx_word), 64'h12345678);
    checkOutput("rx_first_valid_cycles", 64'(valid_cycles), 64'd1);
    checkOutput("rx_first_pops", 64'(pops - p0), 64'd4);

    // RX backpressure with two words queued
    p0 = pops;
    w0 = words_rx;
    i_word_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo.push_back(8'($urandom));
    driveInputs();
    #1;
    repeat (20) applyStimulus();
    checkOutput("rx_bp_pops", 64'(pops - p0), 64'd4);
    checkOutput("rx_bp_valid", 64'(o_word_valid), 64'd1);
    i_word_ready = 1'b1;
    #1;
    repeat (20) applyStimulus();
    checkOutput("rx_bp_words", 64'(words_rx - w0), 64'd2);
    checkOutput("rx_bp_left", 64'(exp_words.size()), 64'd0);

    // TX serialization of 0xDEADBEEF
    s0 = starts;
    d0 = dones;
    tx_src.push_back(32'hDEADBEEF);
    driveInputs();
    #1;
    applyStimulus();
    checkOutput("tx_busy_ready", 64'(o_word_ready), 64'd0);
    n = 0;
    while (!o_word_ready && n < 80) begin
      applyStimulus();
      n++;
    end
    checkOutput("tx_ready_returned", 64'(o_word_ready), 64'd1);
    checkOutput("tx_start_count", 64'(starts - s0), 64'd4);
    checkOutput("tx_done_count", 64'(dones - d0), 64'd4);
    checkOutput("tx_ready_after_done", 64'(cyc - last_done_cyc), 64'd1);
    checkOutput("tx_byte_order", 64'(tx_shift), 64'hDEADBEEF);

    // TX stall while the TX FIFO is full
    s0 = starts;
    i_tx_full = 1'b1;
    tx_src.push_back($urandom);
    driveInputs();
    #1;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("tx_full_no_start", 64'(o_tx_start), 64'd0);
    end
    i_tx_full = 1'b0;
    #1;
    checkOutput("tx_full_drop_same", 64'(o_tx_start), 64'd0);
    applyStimulus();
    checkOutput("tx_full_drop_next", 64'(o_tx_start), 64'd1);
    n = 0;
    while (!o_word_ready && n < 80) begin
      applyStimulus();
      n++;
    end
    checkOutput("tx_full_starts", 64'(starts - s0), 64'd4);

    // Concurrent random RX/TX traffic
    gap_pct = 30;
    for (int i = 0; i < 16; i++) fifo.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) tx_src.push_back($urandom);
    driveInputs();
    #1;
    for (int i = 0; i < 220; i++) begin
      i_word_ready = 1'($urandom_range(1));
      applyStimulus();
    end
    i_word_ready = 1'b1;
    gap_pct = 0;
    #1;
    repeat (10) applyStimulus();
    checkOutput("mix_fifo_drained", 64'(fifo.size()), 64'd0);
    checkOutput("mix_words_left", 64'(exp_words.size()), 64'd0);
    checkOutput("mix_tx_bytes_left", 64'(tx_exp.size()), 64'd0);
    checkOutput("mix_tx_src_left", 64'(tx_src.size()), 64'd0);

    // Reset in the middle of an RX word and a TX word
    p0 = pops;
    s0 = starts;
    w0 = words_rx;
    fifo.push_back(8'($urandom));
    fifo.push_back(8'($urandom));
    tx_src.push_back($urandom);
    driveInputs();
    #1;
    for (n = 0; n < 30 && !(pops >= p0 + 2 && starts >= s0 + 1); n++) applyStimulus();
    checkOutput("midop_rx_progress", 64'(pops - p0), 64'd2);
    checkOutput("midop_tx_progress", 64'(starts - s0), 64'd1);
    for (int i = 0; i < BYTES; i++) begin
      rb = 8'($urandom);
      fifo.push_back(rb);
    end
    i_rst = 1'b1;
    clearModel();
    driveInputs();
    #1;
    checkOutput("midrst_rx_rd", 64'(o_rx_rd), 64'd0);
    checkOutput("midrst_word_ready", 64'(o_word_ready), 64'd0);
    checkOutput("midrst_word_valid", 64'(o_word_valid), 64'd0);
    applyStimulus();
    checkOutput("midrst_word", 64'(o_word), 64'd0);
    checkOutput("midrst_tx_start", 64'(o_tx_start), 64'd0);
    checkOutput("midrst_tx_wdata", 64'(o_tx_wdata), 64'd0);
    s0 = starts;
    i_rst = 1'b0;
    #1;
    checkOutput("midrst_ready_back", 64'(o_word_ready), 64'd1);
    repeat (30) applyStimulus();
    checkOutput("midrst_clean_word", 64'(words_rx - w0), 64'd1);
    checkOutput("midrst_no_tx", 64'(starts - s0), 64'd0);
    checkOutput("midrst_words_left", 64'(exp_words.size()), 64'd0);

    // Starve a partial word
    t0 = timeouts;
    w0 = words_rx;
    fifo.push_back(8'($urandom));
    fifo.push_back(8'($urandom));
    driveInputs();
    #1;
    repeat (TO_CYCLES + 10) applyStimulus();
`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    checkOutput("starve_timeouts", 64'(timeouts - t0), 64'd1);
    checkOutput("starve_part_dropped", 64'(part.size()), 64'd0);
    for (int i = 0; i < BYTES; i++) fifo.push_back(8'($urandom));
`else
    checkOutput("starve_timeouts", 64'(timeouts - t0), 64'd0);
    checkOutput("starve_part_kept", 64'(part.size()), 64'd2);
    for (int i = 0; i < 2; i++) fifo.push_back(8'($urandom));
`endif
    driveInputs();
    #1;
    repeat (12) applyStimulus();
    checkOutput("starve_next_word", 64'(words_rx - w0), 64'd1);
    checkOutput("starve_words_left", 64'(exp_words.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
